mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
Sequential control stage wrapped around the combinational Booth radix-4 multiplier.
- Registers the two operands from the datapath and holds them stable on the multiplier inputs.
- Waits a fixed settle time, then captures the 2*BITS product into the Z-high/Z-low result registers.
- Flags signed overflow and presents the result with a start/done/ack handshake to the control unit.

Parameters:
BITS, 32, operand width; product is 2*BITS.
SETTLE, 2, clock edges allowed for the combinational product to settle; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
clr  input  1  asynchronous active-low reset.
start  input  1  request to multiply a_in by b_in; sampled only when accepting.
ack  input  1  control unit has consumed the result; releases done.
a_in  input  BITS  multiplicand from the bus (two's complement).
b_in  input  BITS  multiplier from the bus (two's complement).
product_in  input  2*BITS  product returned by the combinational multiplier.
mcand_out  output  BITS  registered multiplicand driven to the multiplier.
mplier_out  output  BITS  registered multiplier driven to the multiplier.
busy  output  1  high in WAIT.
done  output  1  high in DONE; result valid.
zhi  output  BITS  product[2*BITS-1:BITS], registered.
zlo  output  BITS  product[BITS-1:0], registered.
ovf  output  1  signed result does not fit in BITS bits.

Behaviour:
Reset (clr=0, asynchronous, any state):
- state=IDLE, cnt=0.
- mcand_out, mplier_out, zhi, zlo = 0; busy, done, ovf = 0.
- An in-flight operation is discarded; nothing is captured.

States and transitions:
- IDLE: on an edge with start=1, capture a_in into mcand_out and b_in into mplier_out, set cnt=0, go to WAIT.
- WAIT:
  - Each edge: cnt <= cnt+1.
  - On the edge where cnt==SETTLE-1: capture zhi/zlo from product_in, compute ovf, go to DONE.
  - start is ignored in WAIT; operand registers do not change.
- DONE: done=1; zhi, zlo, ovf and the operand registers hold.
  - ack=1, start=0: go to IDLE.
  - ack=1, start=1 on the same edge: capture the new operands, cnt=0, go directly to WAIT; done falls, zhi/zlo keep the old result until the new capture.
  - ack=0: stay; start is ignored.

Latency:
- Start sampled at edge E0; done=1 and zhi/zlo valid after edge E0+SETTLE.
- With SETTLE=2: done rises after the second edge following the start edge.

Outputs and arithmetic:
- busy and done are Moore outputs decoded from state and are never high together.
- Operands are two's complement; the product is signed, full width, with no truncation.
- ovf=1 iff zhi != {BITS{zlo[BITS-1]}}. It is computed from product_in at the capture edge and registered with zhi/zlo.
- zhi, zlo and ovf change only at a capture edge or at reset.

Test Plan:
- Reset mid-WAIT: start with a_in=5, b_in=6, drop clr after one edge -> all outputs 0, state IDLE; the next start with 5*6 gives zlo=0x0000001E, zhi=0, ovf=0 after SETTLE edges.
- Signed basic: a_in=0xFFFFFFFD (-3), b_in=7, start for 1 cycle -> busy for 2 cycles; then done=1, zhi=0xFFFFFFFF, zlo=0xFFFFFFEB, ovf=0; done holds until ack.
- Overflow: 0x7FFFFFFF*2 -> zhi=0, zlo=0xFFFFFFFE, ovf=1. 0x80000000*0x80000000 -> zhi=0x40000000, zlo=0, ovf=1.
- Back-to-back: in DONE, assert ack=1 and start=1 with 0x10*0x10 on the same edge -> done falls next cycle, busy rises; after 2 edges done=1, zlo=0x100. Old zhi/zlo hold during WAIT.
- Ignored start: pulse start with different operands during WAIT and during DONE (ack=0) -> mcand_out/mplier_out and the result are unchanged.
- SETTLE=1 instance: 0xFFFFFFFF*0xFFFFFFFF -> done after 1 edge, zhi=0, zlo=1, ovf=0.

Source files
------------

// File: rtl/mul_sequencer.sv
// Control stage around the combinational Booth radix-4 multiplier: latches the
// operands, waits SETTLE edges, captures the signed product and flags overflow.
module mul_sequencer #(
    parameter int BITS   = 32,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              ack,
    input  logic [BITS-1:0]   a_in,
    input  logic [BITS-1:0]   b_in,
    input  logic [2*BITS-1:0] product_in,
    output logic [BITS-1:0]   mcand_out,
    output logic [BITS-1:0]   mplier_out,
    output logic              busy,
    output logic              done,
    output logic [BITS-1:0]   zhi,
    output logic [BITS-1:0]   zlo,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] cnt;

    logic [BITS-1:0] prod_hi;
    logic [BITS-1:0] prod_lo;
    logic            prod_ovf;

    assign prod_hi  = product_in[2*BITS-1:BITS];
    assign prod_lo  = product_in[BITS-1:0];
    // The product fits in BITS bits only if the high half is pure sign extension.
    assign prod_ovf = (prod_hi != {BITS{prod_lo[BITS-1]}});

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            cnt        <= '0;
            mcand_out  <= '0;
            mplier_out <= '0;
            zhi        <= '0;
            zlo        <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_out  <= a_in;
                        mplier_out <= b_in;
                        cnt        <= '0;
                        state      <= WAIT;
                        busy       <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        zhi   <= prod_hi;
                        zlo   <= prod_lo;
                        ovf   <= prod_ovf;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        done <= 1'b0;
                        // A new start alongside ack skips IDLE; the old result stays visible.
                        if (start) begin
                            mcand_out  <= a_in;
                            mplier_out <= b_in;
                            cnt        <= '0;
                            state      <= WAIT;
                            busy       <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
